// File: rtl/shift_seq.sv
// Multi-cycle shift/rotate sequencer driving an external 2-bit shift unit.
// The total distance is split into steps of at most 3, fed back one per cycle through sh_c.
`timescale 1ns/1ps

module shift_seq #(
  parameter time NAND_TIME = 7ns
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] a,
  input  logic       left,
  input  logic       rotate,
  input  logic [2:0] amt,
  output logic [7:0] sh_a,
  output logic       sh_left,
  output logic       sh_rotate,
  output logic [1:0] sh_amt,
  input  logic [7:0] sh_c,
  output logic       busy,
  output logic       done,
  output logic [7:0] result
);

  // No gate-level submodule here, but a zero delay would break any that gets added.
  if (NAND_TIME == 0) begin : g_bad_nand_time
    $error("shift_seq: NAND_TIME must be non-zero");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_next;
  logic [7:0] work;
  logic [2:0] rem;
  logic [2:0] rem_after;
  logic       left_q;
  logic       rotate_q;
  logic [7:0] result_q;
  logic [1:0] step;

  always_comb begin
    state_next = state;
    step       = 2'd0;
    rem_after  = rem;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        // Step never exceeds rem, so rem cannot wrap below zero.
        step      = (rem > 3'd3) ? 2'd3 : rem[1:0];
        rem_after = rem - {1'b0, step};
        if (rem_after == 3'd0) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      work     <= 8'h00;
      rem      <= 3'd0;
      left_q   <= 1'b0;
      rotate_q <= 1'b0;
      result_q <= 8'h00;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            work     <= a;
            rem      <= amt;
            left_q   <= left;
            rotate_q <= rotate;
          end
        end
        RUN: begin
          work <= sh_c;
          rem  <= rem_after;
          if (rem_after == 3'd0) result_q <= sh_c;
        end
        default: ;
      endcase
    end
  end

  assign sh_a      = work;
  assign sh_left   = left_q;
  assign sh_rotate = rotate_q;
  assign sh_amt    = step;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_shift_seq.sv
// Directed testbench for shift_seq with a behavioural 2-bit shift unit closing the loop.
`timescale 1ns/1ps

module tb_shift_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic       left;
  logic       rotate;
  logic [2:0] amt;
  logic [7:0] sh_a;
  logic       sh_left;
  logic       sh_rotate;
  logic [1:0] sh_amt;
  logic [7:0] sh_c;
  logic       busy;
  logic       done;
  logic [7:0] result;

  int checkCount = 0;
  int errorCount = 0;

  shift_seq #(.NAND_TIME(7ns)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .left(left),
    .rotate(rotate), .amt(amt), .sh_a(sh_a), .sh_left(sh_left),
    .sh_rotate(sh_rotate), .sh_amt(sh_amt), .sh_c(sh_c), .busy(busy),
    .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural downstream unit: arithmetic right, zero-fill left, rotate both ways.
  function automatic logic [7:0] shiftModel(input logic [7:0] x, input logic l,
                                            input logic r, input logic [1:0] n);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < 3; i++) begin
      if (i < int'(n)) begin
        if (l) y = r ? {y[6:0], y[7]} : {y[6:0], 1'b0};
        else   y = r ? {y[0], y[7:1]} : {y[7], y[7:1]};
      end
    end
    return y;
  endfunction

  assign sh_c = shiftModel(sh_a, sh_left, sh_rotate, sh_amt);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] av, input logic lv, input logic rv,
                               input logic [2:0] amtv);
    @(negedge clk);
    start  = 1'b1;
    a      = av;
    left   = lv;
    rotate = rv;
    amt    = amtv;
  endtask

  // Waits through the accepting edge, scrambles the inputs, and follows RUN until done.
  task automatic waitResult(input logic lv, input logic rv, output int cycles,
                            output logic [5:0] steps, output logic [7:0] res);
    int guard;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    a      = ~a;
    left   = ~left;
    rotate = ~rotate;
    amt    = ~amt;
    cycles = 0;
    steps  = 6'd0;
    guard  = 0;
    while (!done && guard < 8) begin
      if (busy) begin
        steps = {steps[3:0], sh_amt};
        cycles++;
        checkOutput("sh_left_held", {31'd0, sh_left}, {31'd0, lv});
        checkOutput("sh_rotate_held", {31'd0, sh_rotate}, {31'd0, rv});
      end
      guard++;
      @(negedge clk);
    end
    checkOutput("done_seen", {31'd0, done}, 32'd1);
    checkOutput("busy_done_excl", {31'd0, busy & done}, 32'd0);
    res = result;
  endtask

  task automatic runCheck(input string tag, input logic [7:0] av, input logic lv,
                          input logic rv, input logic [2:0] amtv, input int expCycles,
                          input logic [5:0] expSteps, input logic [7:0] expRes);
    int         cycles;
    logic [5:0] steps;
    logic [7:0] res;
    applyStimulus(av, lv, rv, amtv);
    waitResult(lv, rv, cycles, steps, res);
    checkOutput({tag, "_cycles"}, cycles, expCycles);
    checkOutput({tag, "_steps"}, {26'd0, steps}, {26'd0, expSteps});
    checkOutput({tag, "_result"}, {24'd0, res}, {24'd0, expRes});
    @(negedge clk);
    checkOutput({tag, "_done_once"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_idle_amt"}, {30'd0, sh_amt}, 32'd0);
    checkOutput({tag, "_hold"}, {24'd0, result}, {24'd0, expRes});
  endtask

  initial begin
    int         doneCount;
    int         overlap;
    int         cycles;
    logic [5:0] steps;
    logic [7:0] res;

    rst_n  = 1'b0;
    start  = 1'b0;
    a      = 8'h00;
    left   = 1'b0;
    rotate = 1'b0;
    amt    = 3'd0;
    #1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_result", {24'd0, result}, 32'h00);
    checkOutput("rst_sh_a", {24'd0, sh_a}, 32'h00);
    checkOutput("rst_sh_amt", {30'd0, sh_amt}, 32'd0);
    checkOutput("rst_ctrl", {30'd0, sh_left, sh_rotate}, 32'd0);
    #2 rst_n = 1'b1;

    runCheck("asr7",  8'h80, 1'b0, 1'b0, 3'd7, 3, 6'b11_11_01, 8'hFF);
    runCheck("shl7",  8'h01, 1'b1, 1'b0, 3'd7, 3, 6'b11_11_01, 8'h80);
    runCheck("rol1",  8'h81, 1'b1, 1'b1, 3'd1, 1, 6'b00_00_01, 8'h03);
    runCheck("ror4",  8'h01, 1'b0, 1'b1, 3'd4, 2, 6'b00_11_01, 8'h10);
    runCheck("amt0",  8'h5A, 1'b0, 1'b0, 3'd0, 1, 6'b00_00_00, 8'h5A);
    runCheck("shl5",  8'h3C, 1'b1, 1'b0, 3'd5, 2, 6'b00_11_10, 8'h80);

    // Start held high: one operation every three edges, DONE never re-accepts.
    @(negedge clk);
    start     = 1'b1;
    a         = 8'h10;
    left      = 1'b0;
    rotate    = 1'b0;
    amt       = 3'd2;
    doneCount = 0;
    overlap   = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (done) doneCount++;
      if (busy && done) overlap++;
    end
    start = 1'b0;
    checkOutput("b2b_done_count", doneCount, 3);
    checkOutput("b2b_overlap", overlap, 0);
    checkOutput("b2b_result", {24'd0, result}, 32'h04);
    repeat (3) @(negedge clk);
    checkOutput("b2b_result_hold", {24'd0, result}, 32'h04);
    checkOutput("b2b_idle", {31'd0, busy}, 32'd0);

    // Reset during the second RUN cycle aborts without a done pulse.
    applyStimulus(8'h80, 1'b0, 1'b0, 3'd7);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("mid_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_done", {31'd0, done}, 32'd0);
    checkOutput("mid_rst_result", {24'd0, result}, 32'h00);
    checkOutput("mid_rst_sh_a", {24'd0, sh_a}, 32'h00);
    doneCount = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("mid_no_done", doneCount, 0);

    // Start already high on the first edge after release.
    start  = 1'b1;
    a      = 8'h0F;
    left   = 1'b0;
    rotate = 1'b0;
    amt    = 3'd2;
    #2 rst_n = 1'b1;
    waitResult(1'b0, 1'b0, cycles, steps, res);
    checkOutput("post_rst_cycles", cycles, 1);
    checkOutput("post_rst_steps", {26'd0, steps}, 32'd2);
    checkOutput("post_rst_result", {24'd0, res}, 32'h03);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
